// File: rtl/reliability_msg_type_router.sv
// reliability_msg_type_router
// Steers inbound AXIS packets to one of NUM_OUTPUTS destinations. The route
// comes from a per-output message-type mask, is decided on the first beat and
// is held until tlast. Packets whose type matches no output are discarded and
// counted. Each output owns a registered 2-entry skid buffer, so s_axis_tready
// never depends combinationally on any m_axis_tready.
//
// Handshake: a beat moves on a channel only in a cycle where tvalid and tready
// are both high at the rising edge. A producer holding tvalid keeps the beat
// stable until it is taken, and tvalid never depends on tready.
module reliability_msg_type_router #(
  parameter int AXIS_DATA_WIDTH          = 64,
  parameter int AXIS_KEEP_WIDTH          = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_FROM_NB_TDEST_WIDTH = 16,
  parameter int AXIS_FROM_NB_TUSER_WIDTH = 16,
  parameter int PACKET_MSG_TYPE_WIDTH    = 4,
  parameter int NUM_OUTPUTS              = 2,
  parameter logic [NUM_OUTPUTS*(2**PACKET_MSG_TYPE_WIDTH)-1:0] ROUTE_MASK = {16'h000C, 16'h0003},
  parameter int DROP_CNT_WIDTH           = 16
) (
  input  logic                                             i_clk,
  input  logic                                             i_ap_rst_n,
  input  logic                                             s_axis_tvalid,
  output logic                                             s_axis_tready,
  input  logic [AXIS_DATA_WIDTH-1:0]                       s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0]                       s_axis_tkeep,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0]              s_axis_tid,
  input  logic [AXIS_FROM_NB_TDEST_WIDTH-1:0]              s_axis_tdest,
  input  logic [AXIS_FROM_NB_TUSER_WIDTH-1:0]              s_axis_tuser,
  input  logic                                             s_axis_tlast,
  output logic [NUM_OUTPUTS-1:0]                           m_axis_tvalid,
  input  logic [NUM_OUTPUTS-1:0]                           m_axis_tready,
  output logic [NUM_OUTPUTS*AXIS_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic [NUM_OUTPUTS*AXIS_KEEP_WIDTH-1:0]           m_axis_tkeep,
  output logic [NUM_OUTPUTS*AXIS_FROM_NB_TDEST_WIDTH-1:0]  m_axis_tid,
  output logic [NUM_OUTPUTS*AXIS_FROM_NB_TDEST_WIDTH-1:0]  m_axis_tdest,
  output logic [NUM_OUTPUTS*AXIS_FROM_NB_TUSER_WIDTH-1:0]  m_axis_tuser,
  output logic [NUM_OUTPUTS-1:0]                           m_axis_tlast,
  output logic                                             drop_pulse,
  output logic [DROP_CNT_WIDTH-1:0]                        drop_count
);

  localparam int DW = AXIS_DATA_WIDTH;
  localparam int KW = AXIS_KEEP_WIDTH;
  localparam int IW = AXIS_FROM_NB_TDEST_WIDTH;
  localparam int UW = AXIS_FROM_NB_TUSER_WIDTH;
  localparam int TW = PACKET_MSG_TYPE_WIDTH;
  localparam int NT = 2 ** TW;
  localparam int BW = DW + KW + 2 * IW + UW + 1;
  localparam int SW = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  // Packet FSM state; kept as a named register so checkers can observe it.
  state_t                 state;
  logic [SW-1:0]          fwd_sel;

  logic [TW-1:0]          msg_type;
  logic [NUM_OUTPUTS-1:0] match;
  logic                   hit;
  logic [SW-1:0]          hit_sel;
  logic [SW-1:0]          route_sel;
  logic                   route_ok;
  logic                   accept;
  logic [NUM_OUTPUTS-1:0] wr_en;
  logic [NUM_OUTPUTS-1:0] not_full;
  logic [BW-1:0]          in_beat;

  assign msg_type = s_axis_tdata[TW-1:0];
  assign in_beat  = {s_axis_tdata, s_axis_tkeep, s_axis_tid, s_axis_tdest, s_axis_tuser, s_axis_tlast};
  assign accept   = s_axis_tvalid & s_axis_tready;

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_match
    localparam logic [NT-1:0] MASK_K = ROUTE_MASK[k*NT +: NT];
    assign match[k] = MASK_K[msg_type];
  end

  // Lowest-index matching output wins when masks overlap.
  always_comb begin
    hit     = 1'b0;
    hit_sel = '0;
    for (int k = NUM_OUTPUTS - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit     = 1'b1;
        hit_sel = SW'(k);
      end
    end
  end

  // Route for the current beat and input ready; only registered flags and, in IDLE, the type bits.
  always_comb begin
    route_sel     = fwd_sel;
    route_ok      = 1'b0;
    s_axis_tready = 1'b1;
    case (state)
      ST_IDLE: begin
        route_sel     = hit_sel;
        route_ok      = hit;
        s_axis_tready = hit ? not_full[hit_sel] : 1'b1;
      end
      ST_FWD: begin
        route_ok      = 1'b1;
        s_axis_tready = not_full[fwd_sel];
      end
      default: ;
    endcase
  end

  // Packet FSM: latch the route on the first beat, release it on tlast, count drops.
  always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
    if (!i_ap_rst_n) begin
      state      <= ST_IDLE;
      fwd_sel    <= '0;
      drop_pulse <= 1'b0;
      drop_count <= '0;
    end else begin
      drop_pulse <= 1'b0;
      if (accept) begin
        case (state)
          ST_IDLE: begin
            if (!hit) begin
              drop_pulse <= 1'b1;
              if (drop_count != '1) drop_count <= drop_count + DROP_CNT_WIDTH'(1);
            end
            if (!s_axis_tlast) begin
              state   <= hit ? ST_FWD : ST_DROP;
              fwd_sel <= hit_sel;
            end
          end
          default: begin
            if (s_axis_tlast) state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar k = 0; k < NUM_OUTPUTS; k++) begin : g_skid
    logic [BW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_next;
    logic          nf;
    logic          pop;

    assign wr_en[k]         = accept & route_ok & (route_sel == SW'(k));
    assign pop              = m_axis_tvalid[k] & m_axis_tready[k];
    assign count_next       = count + {1'b0, wr_en[k]} - {1'b0, pop};
    assign not_full[k]      = nf;
    assign m_axis_tvalid[k] = (count != 2'd0);
    assign {m_axis_tdata[k*DW +: DW], m_axis_tkeep[k*KW +: KW], m_axis_tid[k*IW +: IW],
            m_axis_tdest[k*IW +: IW], m_axis_tuser[k*UW +: UW], m_axis_tlast[k]} = mem[rd_ptr];

    // Beat storage; a write never lands on the presented head while it is valid.
    always_ff @(posedge i_clk) begin
      if (wr_en[k]) mem[wr_ptr] <= in_beat;
    end

    // Skid pointers, occupancy and the registered not-full flag.
    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
      if (!i_ap_rst_n) begin
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
        nf     <= 1'b1;
      end else begin
        if (wr_en[k]) wr_ptr <= ~wr_ptr;
        if (pop)      rd_ptr <= ~rd_ptr;
        count <= count_next;
        nf    <= (count_next < 2'd2);
      end
    end
  end

endmodule

// File: doc/reliability_msg_type_router.md
# reliability_msg_type_router

Parametrised, packet-aware successor to the two-way reliability splitter. It sits between the network bridge and the reliability engines and steers each inbound AXIS packet to one of `NUM_OUTPUTS` destinations using a per-output message-type mask. The route is latched on the first beat and held until `tlast`. Packets whose type matches no output are dropped and counted. Every output has a registered 2-entry skid buffer, so no combinational path runs from any `m_tready` to `s_tready`.

## Interface
Parameters:
- `AXIS_DATA_WIDTH`, 64: data width in bits; must be ≥ `PACKET_MSG_TYPE_WIDTH`.
- `AXIS_KEEP_WIDTH`, `AXIS_DATA_WIDTH/8`: tkeep width.
- `AXIS_FROM_NB_TDEST_WIDTH`, 16: width of tid and of tdest.
- `AXIS_FROM_NB_TUSER_WIDTH`, 16: tuser width.
- `PACKET_MSG_TYPE_WIDTH`, 4: message-type field width, taken from `tdata[W-1:0]`.
- `NUM_OUTPUTS`, 2: number of destination ports, 1..8.
- `ROUTE_MASK`, `{16'h000C,16'h0003}`: `NUM_OUTPUTS` × 2^`PACKET_MSG_TYPE_WIDTH` bits; slice k bit t set means type t goes to output k.
- `DROP_CNT_WIDTH`, 16: width of the drop counter.

Ports (the `m_axis_*` ports are flattened, output k occupies slice k):
- `i_clk`, in, 1: the single clock.
- `i_ap_rst_n`, in, 1: asynchronous, active-low reset.
- `s_axis_tvalid` / `s_axis_tready`, in / out, 1 each: input handshake from the network bridge.
- `s_axis_tdata`, `s_axis_tkeep`, `s_axis_tid`, `s_axis_tdest`, `s_axis_tuser`, `s_axis_tlast`, in, parameter widths: input packet beat.
- `m_axis_tvalid` / `m_axis_tready`, out / in, `NUM_OUTPUTS` each: per-output handshake.
- `m_axis_tdata`, `_tkeep`, `_tid`, `_tdest`, `_tuser`, `_tlast`, out, `NUM_OUTPUTS` × width: per-output beat.
- `drop_pulse`, out, 1: high for one cycle when the first beat of a dropped packet is accepted.
- `drop_count`, out, `DROP_CNT_WIDTH`: saturating count of dropped packets.

## Operation
- Decode, from the current `s_axis_tdata[W-1:0]`:
  - `match[k]` = `ROUTE_MASK[k][type]`.
  - Selected output = the lowest k with `match[k]` set.
  - No bits set means no match.
- FSM states:
  - IDLE, first beat of a packet:
    - Matched: `s_axis_tready` = skid k not full.
    - Unmatched: `s_axis_tready` = 1.
    - Accepted matched beat with `tlast=0`: latch k, go to FWD.
    - Accepted unmatched beat with `tlast=0`: go to DROP.
    - Accepted beat with `tlast=1`: stay in IDLE.
  - FWD:
    - The latched k routes every beat. The type field is ignored.
    - `s_axis_tready` = skid k not full.
    - Accepted beat with `tlast=1` goes to IDLE.
  - DROP:
    - `s_axis_tready` = 1. Beats are discarded.
    - Accepted beat with `tlast=1` goes to IDLE.
- Drop accounting:
  - Fires once per dropped packet, on its first accepted beat.
  - `drop_pulse` is asserted for that cycle.
  - `drop_count` increments and saturates at all-ones.
- Skid buffer, per output:
  - 2 entries, each holding the full beat (data, keep, id, dest, user, last).
  - Writes and reads in the same cycle are allowed. Occupancy is 0, 1 or 2.
  - "Not full" is a registered flag (occupancy < 2).
  - `m_axis_tvalid[k]` = occupancy ≠ 0.
  - The head entry is presented; pop on `tvalid & tready`.
- Only one output is written per cycle. Outputs drain independently, so packets to different outputs may be reordered relative to each other. Beat order within one output is preserved.
- Reset (asynchronous, any time, including mid-packet):
  - FSM returns to IDLE and all skids empty.
  - All `m_axis_tvalid` = 0, `drop_pulse` = 0, `drop_count` = 0.
  - `s_axis_tready` follows the IDLE rule, i.e. 1 once reset is released.
  - A partially forwarded packet is abandoned, with no completion beat.

## Timing
- Latency: a beat accepted on cycle N is valid at its output on cycle N+1.
- Throughput: 1 beat per cycle per packet, as long as the destination's `m_axis_tready` stays high.
- `s_axis_tready` depends only on registered state, plus `s_axis_tdata` type bits in IDLE. It never depends on `m_axis_tready`.
- Backpressure: with `m_axis_tready[k]` held low, skid k absorbs 2 beats and `s_axis_tready` falls in the cycle after the 2nd write.
- Output stability: while `m_axis_tvalid[k]=1` and `m_axis_tready[k]=0`, every `m_axis_*[k]` signal holds stable.
- `drop_pulse` is registered: it is high on cycle N+1 for a drop accepted on cycle N. `drop_count` updates on the same edge.

## Test plan
- Defaults (`ROUTE_MASK` outputs 0 = types {0,1}, 1 = types {2,3}):
  - Send type-1 packet of 4 beats → out0 gets 4 beats in order, `tlast` on the 4th, each 1 cycle after acceptance.
  - Then send type-2 packet → out1 gets the same treatment.
- Beats 2..4 of a type-0 packet carry type bits 3 → all beats still go to out0 (route latched).
- Type 7, 3 beats, then a 1-beat type-5 packet → nothing appears on any output. `s_axis_tready` stays 1 throughout, `drop_count`=2, and 2 `drop_pulse`s are seen.
- Hold `m_axis_tready[0]`=0 and stream 5 beats to out0 → exactly 2 accepted, `s_axis_tready`=0. Release → remaining 3 drain with no loss or duplication and outputs stable while stalled.
- Out1 stalled with 2 beats buffered, then a new type-0 packet → out0 flows at full rate and out1 contents are unchanged.
- Assert `i_ap_rst_n` mid-packet with both skids holding data → all `tvalid`=0 immediately. After release a fresh type-3 packet routes to out1 and `drop_count`=0.
- `NUM_OUTPUTS`=4, `DROP_CNT_WIDTH`=2, with overlapping masks → overlapping type goes to the lowest index, and `drop_count` saturates at 3.
